// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between the FMC bridge (absolute priority) and NREQ round-robin masters.
// Define ARB_WATCHDOG_EN to force-release any grant held for MAX_HOLD consecutive cycles.
module bram_port_arbiter #(
  parameter int AW       = 11,
  parameter int DW       = 32,
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 256
) (
  input  logic               fmc_clk,
  input  logic               rst,
  input  logic               fmc_en,
  input  logic               fmc_we,
  input  logic [AW-1:0]      fmc_a,
  input  logic [DW-1:0]      fmc_di,
  output logic [DW-1:0]      fmc_do,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_last,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_di,
  output logic [NREQ-1:0]    gnt,
  output logic               stall,
  output logic [DW-1:0]      req_do,
  output logic               bram_en,
  output logic               bram_we,
  output logic [AW-1:0]      bram_a,
  output logic [DW-1:0]      bram_do,
  input  logic [DW-1:0]      bram_di,
  output logic               wdog_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, GRANT} stateT;

  stateT           r_state, w_stateNxt;
  logic [NREQ-1:0] r_gnt, w_gntNxt;
  logic [PW-1:0]   r_ptr, w_ptrNxt;
  logic [PW-1:0]   w_own, w_ptrRel;
  logic [NREQ-1:0] w_others;
  logic            w_stall, w_release, w_fire;

  if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 1) begin : g_badParams
    $error("bram_port_arbiter: NREQ must be 2..8 and MAX_HOLD at least 1");
  end

  // First set bit of vec at or after start, wrapping past NREQ-1 back to 0.
  function automatic logic [PW-1:0] rrPick(input logic [NREQ-1:0] vec, input logic [PW-1:0] start);
    logic [PW:0] idx;
    logic        found;
    rrPick = start;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, start} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && vec[idx[PW-1:0]]) begin
        rrPick = idx[PW-1:0];
        found  = 1'b1;
      end
    end
  endfunction

  always_comb begin
    w_own = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_gnt[k]) w_own = PW'(k);
    end
  end

  always_comb begin
    bram_en = 1'b0;
    bram_we = 1'b0;
    bram_a  = '0;
    bram_do = '0;
    if (fmc_en) begin
      bram_en = 1'b1;
      bram_we = fmc_we;
      bram_a  = fmc_a;
      bram_do = fmc_di;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (r_gnt[k]) begin
          bram_en = req[k];
          bram_we = req[k] & req_we[k];
          bram_a  = req_a[AW*k +: AW];
          bram_do = req_di[DW*k +: DW];
        end
      end
    end
  end

  // A stalled cycle never completes an access, so req_last is only honoured when the port is ours.
  assign w_stall   = fmc_en & (|r_gnt);
  assign w_release = (r_state == GRANT) &
                     ((~|(req & r_gnt)) | ((~w_stall) & (|(req & req_last & r_gnt))) | w_fire);
  assign w_ptrRel  = (w_own == PW'(NREQ - 1)) ? '0 : w_own + PW'(1);
  assign w_others  = req & ~r_gnt;

  always_comb begin
    w_stateNxt = r_state;
    w_gntNxt   = r_gnt;
    w_ptrNxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_gntNxt                     = '0;
          w_gntNxt[rrPick(req, r_ptr)] = 1'b1;
          w_stateNxt                   = GRANT;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_ptrNxt = w_ptrRel;
          w_gntNxt = '0;
          if (|w_others) w_gntNxt[rrPick(w_others, w_ptrRel)] = 1'b1;
          else           w_stateNxt = IDLE;
        end
      end
      default: begin
        w_stateNxt = IDLE;
        w_gntNxt   = '0;
      end
    endcase
  end

  always_ff @(posedge fmc_clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_stateNxt;
      r_gnt   <= w_gntNxt;
      r_ptr   <= w_ptrNxt;
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] r_holdCnt;
  logic          r_wdogErr;

  // The count restarts whenever ownership changes, so it measures one uninterrupted grant.
  assign w_fire = (r_state == GRANT) && (r_holdCnt == CW'(MAX_HOLD - 1));

  always_ff @(posedge fmc_clk or posedge rst) begin
    if (rst) begin
      r_holdCnt <= '0;
      r_wdogErr <= 1'b0;
    end else begin
      r_wdogErr <= w_fire;
      if (r_state == GRANT && !w_release) r_holdCnt <= r_holdCnt + CW'(1);
      else                                r_holdCnt <= '0;
    end
  end

  assign wdog_err = r_wdogErr;
`else
  assign w_fire   = 1'b0;
  assign wdog_err = 1'b0;
`endif

  assign gnt    = r_gnt;
  assign stall  = w_stall;
  assign fmc_do = bram_di;
  assign req_do = bram_di;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model. Honours ARB_WATCHDOG_EN.
module tb_bram_port_arbiter;

  localparam int AW   = 11;
  localparam int DW   = 32;
  localparam int NREQ = 4;
`ifdef ARB_WATCHDOG_EN
  localparam int MAX_HOLD = 8;
  localparam bit WDOG_ON  = 1'b1;
`else
  localparam int MAX_HOLD = 256;
  localparam bit WDOG_ON  = 1'b0;
`endif

  logic               fmc_clk;
  logic               rst;
  logic               fmc_en;
  logic               fmc_we;
  logic [AW-1:0]      fmc_a;
  logic [DW-1:0]      fmc_di;
  logic [DW-1:0]      fmc_do;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_a;
  logic [NREQ*DW-1:0] req_di;
  logic [NREQ-1:0]    gnt;
  logic               stall;
  logic [DW-1:0]      req_do;
  logic               bram_en;
  logic               bram_we;
  logic [AW-1:0]      bram_a;
  logic [DW-1:0]      bram_do;
  logic [DW-1:0]      bram_di;
  logic               wdog_err;

  logic [AW-1:0] mA [NREQ];
  logic [DW-1:0] mD [NREQ];

  int nChecks = 0;
  int nFails  = 0;

  bram_port_arbiter #(
    .AW(AW), .DW(DW), .NREQ(NREQ), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .fmc_clk(fmc_clk), .rst(rst),
    .fmc_en(fmc_en), .fmc_we(fmc_we), .fmc_a(fmc_a), .fmc_di(fmc_di), .fmc_do(fmc_do),
    .req(req), .req_last(req_last), .req_we(req_we), .req_a(req_a), .req_di(req_di),
    .gnt(gnt), .stall(stall), .req_do(req_do),
    .bram_en(bram_en), .bram_we(bram_we), .bram_a(bram_a), .bram_do(bram_do), .bram_di(bram_di),
    .wdog_err(wdog_err)
  );

  // Each master's address/data lives in its own array slot and is packed onto the shared buses.
  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_a[AW*g +: AW]  = mA[g];
    assign req_di[DW*g +: DW] = mD[g];
  end

  initial fmc_clk = 1'b0;
  always #5 fmc_clk = ~fmc_clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = nobody), round-robin pointer, cycles held so far.
  int               mOwner = -1;
  int               mPtr   = 0;
  int               mHold  = 0;
  bit               mErr   = 1'b0;
  bit               mFire;
  bit               mRel;
  logic [NREQ-1:0]  mOthers;

  function automatic int firstFrom(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge fmc_clk or posedge rst) begin
    if (rst) begin
      mOwner = -1;
      mPtr   = 0;
      mHold  = 0;
      mErr   = 1'b0;
    end else begin
      mErr = 1'b0;
      if (mOwner < 0) begin
        mOwner = firstFrom(req, mPtr);
        mHold  = 0;
      end else begin
        mFire = WDOG_ON && (mHold == MAX_HOLD - 1);
        mRel  = !req[mOwner] || (!fmc_en && req_last[mOwner]) || mFire;
        mErr  = mFire;
        if (mRel) begin
          mPtr             = (mOwner + 1) % NREQ;
          mOthers          = req;
          mOthers[mOwner]  = 1'b0;
          mOwner           = firstFrom(mOthers, mPtr);
          mHold            = 0;
        end else begin
          mHold++;
        end
      end
    end
  end

  // Every cycle, the port must show what the model's owner and the FMC inputs dictate.
  logic [NREQ-1:0] eGnt;
  logic            eEn, eWe;
  logic [AW-1:0]   eA;
  logic [DW-1:0]   eDo;

  always @(negedge fmc_clk) begin
    eGnt = '0;
    eEn  = 1'b0;
    eWe  = 1'b0;
    eA   = '0;
    eDo  = '0;
    if (mOwner >= 0) eGnt[mOwner] = 1'b1;
    if (fmc_en) begin
      eEn = 1'b1;
      eWe = fmc_we;
      eA  = fmc_a;
      eDo = fmc_di;
    end else if (mOwner >= 0) begin
      eEn = req[mOwner];
      eWe = req[mOwner] && req_we[mOwner];
      eA  = mA[mOwner];
      eDo = mD[mOwner];
    end
    checkOutput("gnt", gnt, eGnt);
    checkOutput("stall", stall, fmc_en && (mOwner >= 0));
    checkOutput("bram_en", bram_en, eEn);
    checkOutput("bram_we", bram_we, eWe);
    checkOutput("bram_a", bram_a, eA);
    checkOutput("bram_do", bram_do, eDo);
    checkOutput("fmc_do", fmc_do, bram_di);
    checkOutput("req_do", req_do, bram_di);
    checkOutput("wdog_err", wdog_err, mErr);
  end

  task automatic nextCycle();
    @(posedge fmc_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l, input logic fe);
    req      = r;
    req_last = l;
    fmc_en   = fe;
  endtask

  task automatic expectPort(input string tag, input logic [NREQ-1:0] g, input logic en,
                            input logic [AW-1:0] a);
    #2;
    checkOutput({tag, ".gnt"}, gnt, g);
    checkOutput({tag, ".bram_en"}, bram_en, en);
    checkOutput({tag, ".bram_a"}, bram_a, a);
  endtask

  task automatic doReset();
    applyStimulus('0, '0, 1'b0);
    fmc_we = 1'b0;
    rst    = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  logic [NREQ-1:0] t2Gnt [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
  logic [AW-1:0]   t2A   [4] = '{11'h0A0, 11'h0A1, 11'h0A3, 11'h0A0};

  initial begin
    rst = 1'b0; fmc_en = 1'b0; fmc_we = 1'b0; fmc_a = '0; fmc_di = '0;
    req = '0; req_last = '0; req_we = '0; bram_di = 32'h1234_5678;
    for (int i = 0; i < NREQ; i++) begin
      mA[i] = '0;
      mD[i] = DW'(32'hA000_0000 + i);
    end
    #1;
    doReset();

    // Single master, 4-word burst at 0x010.
    mA[2] = 11'h010; req_we = 4'b0100;
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    expectPort("t1.req", 4'b0000, 1'b0, 11'h000);
    for (int b = 0; b < 4; b++) begin
      nextCycle();
      mA[2] = 11'h010 + AW'(b);
      applyStimulus(4'b0100, (b == 3) ? 4'b0100 : 4'b0000, 1'b0);
      expectPort("t1.beat", 4'b0100, 1'b1, 11'h010 + AW'(b));
      checkOutput("t1.bram_we", bram_we, 1'b1);
    end
    nextCycle();
    applyStimulus('0, '0, 1'b0);
    expectPort("t1.done", 4'b0000, 1'b0, 11'h000);
    nextCycle();

    // Three masters, 1-word bursts, master 0 re-requests straight away.
    doReset();
    mA[0] = 11'h0A0; mA[1] = 11'h0A1; mA[3] = 11'h0A3; req_we = '0;
    applyStimulus(4'b1011, 4'b1011, 1'b0);
    expectPort("t2.idle", 4'b0000, 1'b0, 11'h000);
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      applyStimulus(4'b1011, 4'b1011, 1'b0);
      expectPort("t2.rr", t2Gnt[k], 1'b1, t2A[k]);
    end
    nextCycle();
    applyStimulus('0, '0, 1'b0);
    nextCycle();
    nextCycle();

    // FMC write preempts master 1 for two cycles; req_last under stall is ignored.
    doReset();
    mA[1] = 11'h100; req_we = 4'b0010;
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    nextCycle();
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    expectPort("t3.beat0", 4'b0010, 1'b1, 11'h100);
    nextCycle();
    mA[1] = 11'h101; fmc_we = 1'b1; fmc_a = 11'h7FF; fmc_di = 32'hDEAD_BEEF;
    for (int c = 0; c < 2; c++) begin
      applyStimulus(4'b0010, (c == 1) ? 4'b0010 : 4'b0000, 1'b1);
      expectPort("t3.fmc", 4'b0010, 1'b1, 11'h7FF);
      checkOutput("t3.bram_we", bram_we, 1'b1);
      checkOutput("t3.stall", stall, 1'b1);
      checkOutput("t3.bram_do", bram_do, 32'hDEAD_BEEF);
      nextCycle();
    end
    fmc_we = 1'b0;
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    expectPort("t3.retry", 4'b0010, 1'b1, 11'h101);
    checkOutput("t3.stall_off", stall, 1'b0);
    nextCycle();
    applyStimulus('0, '0, 1'b0);
    expectPort("t3.done", 4'b0000, 1'b0, 11'h000);
    nextCycle();

    // Master 0 aborts with master 2 pending; then master 2 aborts and the pointer moves to 3.
    doReset();
    mA[0] = 11'h0B0; mA[2] = 11'h0B2; mA[3] = 11'h0B3; req_we = '0;
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    nextCycle();
    applyStimulus(4'b0101, 4'b0000, 1'b0);
    expectPort("t4.own0", 4'b0001, 1'b1, 11'h0B0);
    nextCycle();
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    expectPort("t4.abort", 4'b0001, 1'b0, 11'h0B0);
    nextCycle();
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    expectPort("t4.handoff", 4'b0100, 1'b0, 11'h0B2);
    nextCycle();
    applyStimulus(4'b1001, 4'b0000, 1'b0);
    expectPort("t4.idle", 4'b0000, 1'b0, 11'h000);
    nextCycle();
    applyStimulus('0, '0, 1'b0);
    expectPort("t4.ptr", 4'b1000, 1'b0, 11'h0B3);
    nextCycle();
    nextCycle();

    // Asynchronous reset mid-burst, after a release moved the pointer to 2.
    doReset();
    mA[0] = 11'h0C0; mA[1] = 11'h0C1; mA[3] = 11'h0C3;
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    nextCycle();
    applyStimulus(4'b0010, 4'b0010, 1'b0);
    expectPort("t5.m1", 4'b0010, 1'b1, 11'h0C1);
    nextCycle();
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    expectPort("t5.gap", 4'b0000, 1'b0, 11'h000);
    nextCycle();
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    expectPort("t5.m3", 4'b1000, 1'b1, 11'h0C3);
    nextCycle();
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    #1 rst = 1'b1;
    #1;
    checkOutput("t5.rst_gnt", gnt, 4'b0000);
    checkOutput("t5.rst_en", bram_en, 1'b0);
    checkOutput("t5.rst_stall", stall, 1'b0);
    applyStimulus(4'b1011, 4'b0000, 1'b0);
    #1 rst = 1'b0;
    nextCycle();
    applyStimulus('0, '0, 1'b0);
    expectPort("t5.restart", 4'b0001, 1'b0, 11'h0C0);
    nextCycle();
    nextCycle();

    // Master 3 holds its request without ever finishing the burst.
    doReset();
    mA[3] = 11'h0D3;
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    nextCycle();
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(4'b1000, 4'b0000, 1'b0);
      expectPort("t6.hold", 4'b1000, 1'b1, 11'h0D3);
      checkOutput("t6.err_low", wdog_err, 1'b0);
      nextCycle();
    end
`ifdef ARB_WATCHDOG_EN
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    expectPort("t6.forced", 4'b0000, 1'b0, 11'h000);
    checkOutput("t6.err_pulse", wdog_err, 1'b1);
    nextCycle();
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    expectPort("t6.regrant", 4'b1000, 1'b1, 11'h0D3);
    checkOutput("t6.err_clear", wdog_err, 1'b0);
    nextCycle();
`else
    repeat (292) begin
      applyStimulus(4'b1000, 4'b0000, 1'b0);
      nextCycle();
    end
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    expectPort("t6.unbounded", 4'b1000, 1'b1, 11'h0D3);
    checkOutput("t6.err_never", wdog_err, 1'b0);
    nextCycle();
`endif
    applyStimulus('0, '0, 1'b0);
    nextCycle();
    nextCycle();

    // Random traffic: sticky requests, random burst ends, FMC bursts, random data everywhere.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) req[i] = ($urandom_range(99) < 85);
        else        req[i] = ($urandom_range(99) < 30);
        req_last[i] = ($urandom_range(99) < 25);
        req_we[i]   = 1'($urandom_range(1));
        mA[i]       = AW'($urandom);
        mD[i]       = $urandom;
      end
      fmc_en  = ($urandom_range(99) < 20);
      fmc_we  = 1'($urandom_range(1));
      fmc_a   = AW'($urandom);
      fmc_di  = $urandom;
      bram_di = $urandom;
      nextCycle();
    end
    applyStimulus('0, '0, 1'b0);
    nextCycle();
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
